// File: rtl/pc_sequencer.sv
// Program-counter owner and fetch sequencer: arbitrates sequential fetch, stalls,
// EX-stage redirects, halt drain and misaligned-target trap; drives IF/ID, ID/EX controls.
`timescale 1ns/1ps
module pc_sequencer #(
  parameter int              PC_W         = 9,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Halt,
  input  logic [PC_W-1:0] Ex_PC,
  input  logic            Resume,
  output logic [PC_W-1:0] Cur_PC,
  output logic            PC_En,
  output logic            Flush_IFID,
  output logic            Flush_IDEX,
  output logic            Halted,
  output logic            Misalign,
  output logic [15:0]     Br_Count
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT, S_TRAP} state_t;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);
  localparam logic [3:0]      DRAIN_N = 4'(DRAIN_CYCLES);

  state_t          state, state_n;
  logic [PC_W-1:0] pc_n;
  logic [3:0]      drain_cnt, drain_cnt_n;
  logic [15:0]     br_count_n;
  logic            misalign_n;

  // Target bits above the PC width are architecturally dropped.
  generate
    if (PC_W < 32) begin : g_trunc
      logic br_hi_unused;
      assign br_hi_unused = ^BrPC[31:PC_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      Cur_PC    <= RESET_PC;
      drain_cnt <= '0;
      Br_Count  <= '0;
      Misalign  <= 1'b0;
    end else begin
      state     <= state_n;
      Cur_PC    <= pc_n;
      drain_cnt <= drain_cnt_n;
      Br_Count  <= br_count_n;
      Misalign  <= misalign_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = Cur_PC;
    drain_cnt_n = drain_cnt;
    br_count_n  = Br_Count;
    misalign_n  = Misalign;
    PC_En       = 1'b0;
    Flush_IFID  = 1'b0;
    Flush_IDEX  = 1'b0;
    Halted      = 1'b0;

    case (state)
      S_RUN: begin
        if (Halt) begin
          // Refetch point is the instruction after the halt; any same-cycle redirect is dropped.
          pc_n        = Ex_PC + PC_STEP;
          Flush_IFID  = 1'b1;
          Flush_IDEX  = 1'b1;
          drain_cnt_n = 4'd1;
          state_n     = S_DRAIN;
        end else if (PcSel && (BrPC[1:0] != 2'b00)) begin
          Flush_IFID = 1'b1;
          Flush_IDEX = 1'b1;
          misalign_n = 1'b1;
          state_n    = S_TRAP;
        end else if (PcSel) begin
          // Redirect wins over a stall: the stalled ID instruction is on the wrong path.
          pc_n       = BrPC[PC_W-1:0];
          PC_En      = 1'b1;
          Flush_IFID = 1'b1;
          Flush_IDEX = 1'b1;
          if (Br_Count != 16'hFFFF) br_count_n = Br_Count + 16'd1;
        end else if (Stall) begin
          Flush_IDEX = 1'b1;
        end else begin
          pc_n  = Cur_PC + PC_STEP;
          PC_En = 1'b1;
        end
      end

      S_DRAIN: begin
        Flush_IFID = 1'b1;
        Flush_IDEX = 1'b1;
        if (drain_cnt == DRAIN_N) state_n = S_HALT;
        else                      drain_cnt_n = drain_cnt + 4'd1;
      end

      S_HALT: begin
        Halted     = 1'b1;
        Flush_IFID = 1'b1;
        Flush_IDEX = 1'b1;
        if (Resume) state_n = S_RUN;
      end

      S_TRAP: begin
        Flush_IFID = 1'b1;
        Flush_IDEX = 1'b1;
      end

      default: state_n = S_RUN;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, redirect, stall, wrap,
// halt/drain/resume, misalign trap and redirect-counter saturation.
`timescale 1ns/1ps
module tb_pc_sequencer;

  localparam int PC_W = 9;

  logic            clk = 1'b0;
  logic            reset, Stall, PcSel, Halt, Resume;
  logic [31:0]     BrPC;
  logic [PC_W-1:0] Ex_PC;
  logic [PC_W-1:0] Cur_PC;
  logic            PC_En, Flush_IFID, Flush_IDEX, Halted, Misalign;
  logic [15:0]     Br_Count;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(.PC_W(PC_W), .RESET_PC('0), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .PcSel(PcSel), .BrPC(BrPC),
    .Halt(Halt), .Ex_PC(Ex_PC), .Resume(Resume), .Cur_PC(Cur_PC),
    .PC_En(PC_En), .Flush_IFID(Flush_IFID), .Flush_IDEX(Flush_IDEX),
    .Halted(Halted), .Misalign(Misalign), .Br_Count(Br_Count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic en, input logic fi, input logic fd);
    chk({tag, ".PC_En"}, 32'(PC_En), 32'(en));
    chk({tag, ".Flush_IFID"}, 32'(Flush_IFID), 32'(fi));
    chk({tag, ".Flush_IDEX"}, 32'(Flush_IDEX), 32'(fd));
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; PcSel = 1'b0; Halt = 1'b0; Resume = 1'b0;
    BrPC = '0; Ex_PC = '0;
    tick(); tick();
    reset = 1'b0; #1;

    // Reset state
    chk("rst.Cur_PC", 32'(Cur_PC), 32'h0);
    chk("rst.Br_Count", 32'(Br_Count), 32'h0);
    chk("rst.Misalign", 32'(Misalign), 32'h0);
    chk("rst.Halted", 32'(Halted), 32'h0);
    chk_ctl("rst", 1'b1, 1'b0, 1'b0);

    // Sequential fetch
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("seq.Cur_PC", 32'(Cur_PC), 32'(4 * i));
    end
    chk_ctl("seq", 1'b1, 1'b0, 1'b0);

    // Aligned redirect from 0x10 to 0x40
    PcSel = 1'b1; BrPC = 32'h40; #1;
    chk_ctl("br", 1'b1, 1'b1, 1'b1);
    tick(); PcSel = 1'b0; #1;
    chk("br.Cur_PC", 32'(Cur_PC), 32'h40);
    chk("br.Br_Count", 32'(Br_Count), 32'h1);
    tick();
    chk("br.next", 32'(Cur_PC), 32'h44);

    // Two-cycle stall
    Stall = 1'b1; #1;
    chk_ctl("stall", 1'b0, 1'b0, 1'b1);
    tick(); chk("stall.c1", 32'(Cur_PC), 32'h44);
    tick(); chk("stall.c2", 32'(Cur_PC), 32'h44);
    Stall = 1'b0;
    tick(); chk("stall.rel", 32'(Cur_PC), 32'h48);

    // Redirect overrides stall
    Stall = 1'b1; PcSel = 1'b1; BrPC = 32'h80; #1;
    chk_ctl("brstall", 1'b1, 1'b1, 1'b1);
    tick(); Stall = 1'b0; PcSel = 1'b0; #1;
    chk("brstall.Cur_PC", 32'(Cur_PC), 32'h80);
    chk("brstall.Br_Count", 32'(Br_Count), 32'h2);

    // Wrap at the top of the PC space
    PcSel = 1'b1; BrPC = 32'h1FC;
    tick(); PcSel = 1'b0; #1;
    chk("wrap.pre", 32'(Cur_PC), 32'h1FC);
    tick();
    chk("wrap.post", 32'(Cur_PC), 32'h000);

    // Target truncated to PC width
    PcSel = 1'b1; BrPC = 32'h0000_0208;
    tick(); PcSel = 1'b0; #1;
    chk("trunc.Cur_PC", 32'(Cur_PC), 32'h008);
    chk("trunc.Br_Count", 32'(Br_Count), 32'h4);

    // Halt with a same-cycle redirect, then drain (inputs ignored)
    Halt = 1'b1; Ex_PC = 9'h20; PcSel = 1'b1; BrPC = 32'h100; #1;
    chk_ctl("halt", 1'b0, 1'b1, 1'b1);
    tick(); Halt = 1'b0; Stall = 1'b1; Resume = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("drain.Halted", 32'(Halted), 32'h0);
      chk("drain.Cur_PC", 32'(Cur_PC), 32'h24);
      chk_ctl("drain", 1'b0, 1'b1, 1'b1);
      tick();
    end
    Stall = 1'b0; Resume = 1'b0; #1;
    chk("halt.Halted", 32'(Halted), 32'h1);
    chk("halt.Cur_PC", 32'(Cur_PC), 32'h24);
    chk("halt.Br_Count", 32'(Br_Count), 32'h4);
    tick();
    chk("halt.hold", 32'(Cur_PC), 32'h24);
    chk("halt.stay", 32'(Halted), 32'h1);

    // Resume
    PcSel = 1'b0; Resume = 1'b1; #1;
    chk_ctl("resume", 1'b0, 1'b1, 1'b1);
    tick(); #1;
    chk("resume.Halted", 32'(Halted), 32'h0);
    chk("resume.Cur_PC", 32'(Cur_PC), 32'h24);
    chk_ctl("resume.run", 1'b1, 1'b0, 1'b0);
    tick();
    chk("resume.next", 32'(Cur_PC), 32'h28);
    tick();
    chk("resume.inrun", 32'(Cur_PC), 32'h2C);
    Resume = 1'b0;

    // Misaligned target -> sticky trap
    PcSel = 1'b1; BrPC = 32'h42; #1;
    chk_ctl("trap.entry", 1'b0, 1'b1, 1'b1);
    tick(); BrPC = 32'h40; Stall = 1'b1; Halt = 1'b1; Resume = 1'b1; #1;
    chk("trap.Misalign", 32'(Misalign), 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("trap.Cur_PC", 32'(Cur_PC), 32'h2C);
      chk("trap.Br_Count", 32'(Br_Count), 32'h4);
      chk("trap.Misalign", 32'(Misalign), 32'h1);
      chk("trap.PC_En", 32'(PC_En), 32'h0);
    end
    PcSel = 1'b0; Stall = 1'b0; Halt = 1'b0; Resume = 1'b0;

    // Reset out of trap
    reset = 1'b1;
    tick(); reset = 1'b0; #1;
    chk("rst2.Cur_PC", 32'(Cur_PC), 32'h0);
    chk("rst2.Misalign", 32'(Misalign), 32'h0);
    chk("rst2.Br_Count", 32'(Br_Count), 32'h0);
    chk_ctl("rst2", 1'b1, 1'b0, 1'b0);

    // Redirect counter saturation
    PcSel = 1'b1; BrPC = 32'h40;
    repeat (65534) tick();
    chk("sat.pre", 32'(Br_Count), 32'hFFFE);
    repeat (4466) tick();
    chk("sat.Br_Count", 32'(Br_Count), 32'hFFFF);
    chk("sat.Cur_PC", 32'(Cur_PC), 32'h40);
    PcSel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
